// File: rtl/clkdiv_prog.sv
// Programmable clock-enable divider: runtime-loadable ratio N, ~50% square wave and one-cycle
// tick per period. Reloads take effect only at a wrap, so periods are never cut short.
module clkdiv_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active,
  output logic             pending
);

  localparam logic [WIDTH-1:0] DivRst = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DivMin = WIDTH'(2);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] half_ceil;
  logic             at_last;
  logic             wrap;

  // Ratios below 2 are clamped at capture so div_active can never hold 0 or 1.
  assign load_val  = (div_in < DivMin) ? DivMin : div_in;
  assign count_inc = count_q + WIDTH'(1);
  assign half_ceil = (div_active_q >> 1) + {{(WIDTH-1){1'b0}}, div_active_q[0]};
  assign at_last   = (count_q == (div_active_q - WIDTH'(1)));
  assign wrap      = en & at_last;

  always_comb begin
    count_d      = count_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    div_active_d = div_active_q;
    pend_div_d   = pend_div_q;
    pending_d    = pending_q;

    if (wrap) begin
      count_d   = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b1;
      pending_d = 1'b0;
      // A load coinciding with the wrap beats any older pending ratio.
      if (div_load) begin
        div_active_d = load_val;
      end else if (pending_q) begin
        div_active_d = pend_div_q;
      end
    end else begin
      if (en) begin
        count_d   = count_inc;
        clk_out_d = (count_inc >= half_ceil);
      end
      if (div_load) begin
        pend_div_d = load_val;
        pending_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      div_active_q <= DivRst;
      pend_div_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      div_active_q <= div_active_d;
      pend_div_q   <= pend_div_d;
      pending_q    <= pending_d;
    end
  end

  assign count      = count_q;
  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign div_active = div_active_q;
  assign pending    = pending_q;

endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Programmable, parametrised clock-enable divider: a successor to the fixed divide-by-32 divider. It counts system clocks against a runtime-loadable divide ratio N. It produces a registered ~50% duty divided square wave and a one-cycle tick strobe per period. Sits between the board clock and slow logic such as display scan, debouncers and blink timers. Downstream logic uses `tick` as a clock enable on `clk` and does not use `clk_out` as a clock.

## Interface

- `WIDTH`, 16: width of counter and divide ratio.
- `DEFAULT_DIV`, 32: divide ratio N after reset. Must be 2 to 2^WIDTH-1.

- `clk`  in  1: system clock. The only clock in the block.
- `rst`  in  1: reset, synchronous, active-high.
- `en`  in  1: count enable. When 0, the divider freezes.
- `div_in`  in  WIDTH: requested divide ratio N.
- `div_load`  in  1: single-cycle strobe that captures `div_in`.
- `clk_out`  out  1: registered divided square wave.
- `tick`  out  1: registered one-cycle pulse, one per period.
- `count`  out  WIDTH: current phase, from 0 to N-1.
- `div_active`  out  WIDTH: ratio N currently in effect.
- `pending`  out  1: a loaded ratio is waiting for the next wrap.

## Operation

- **Reset.** All state clears on a `clk` edge with `rst`=1. Reset has priority over every other input, including mid-period and mid-pending.
  - `count`=0, `clk_out`=0, `tick`=0, `pending`=0.
  - `div_active`=DEFAULT_DIV; the pending register is cleared.
- **Clamp.** A captured `div_in` < 2 is stored as 2. Clamping happens at capture, so `div_active` never holds 0 or 1.
- **Counting (`en`=1).**
  - If `count` < N-1, then `count` ← `count`+1.
  - If `count` = N-1 (wrap), then `count` ← 0.
- **clk_out.** Registered and updated on the same edge as `count`. It equals 1 exactly when the new `count` ≥ ceil(N/2).
  - Low phase: ceil(N/2) cycles. High phase: floor(N/2) cycles.
  - N=32 gives 16 low / 16 high, identical to the fixed divider's count[4].
- **tick.** Registered. It is 1 for exactly the one cycle following a wrap edge, i.e. while `count`=0 after a wrap. It is 0 at all other times, including the `count`=0 state right after reset.
- **Hold (`en`=0).** `count`, `clk_out` and `div_active` hold. `tick` is 0 on every cycle after the edge where `en` was sampled 0. No wrap occurs, so `pending` keeps waiting.
- **Ratio reload.**
  - `div_load`=1 captures clamp(`div_in`) into the pending register and sets `pending`=1.
  - A later load before the wrap overwrites the pending value; the last load wins.
  - On the next wrap edge, `div_active` ← pending value and `pending` ← 0. The new period starts at `count`=0 using the new N.
  - A load in the same cycle as a wrap applies immediately at that wrap edge, and `pending` stays 0.
  - The current period is never truncated or extended by a reload.
- **Arithmetic.** All compares are unsigned and WIDTH bits wide. ceil(N/2) = (N>>1) + N[0]. No carry beyond WIDTH; N ≤ 2^WIDTH-1 guarantees `count` never overflows.

## Timing

- All outputs are registered and change only on `clk` rising edges. No combinational path runs from inputs to outputs.
- After `rst` falls with `en`=1 held:
  - `count` reads 1 after the first edge.
  - `clk_out` first rises on the edge where `count` becomes ceil(N/2).
  - First `tick` appears after edge N. Ticks then repeat every N cycles.
- `div_load` to `div_active` latency: the remaining cycles to the next wrap edge, between 1 and N cycles with `en`=1. It is unbounded while `en`=0.
- Deasserting `en` for k cycles delays every later event by exactly k cycles.
- Target: one compare plus one incrementer per cycle. No multi-cycle paths.

## Test plan

- **Default ratio.** Reset, then `en`=1 for 100 cycles.
  - `tick` pulses on cycles 32, 64 and 96.
  - `clk_out` is low 16 / high 16, with its first rise at cycle 16.
  - `div_active`=32 throughout.
- **Odd ratio and clamp.**
  - Load `div_in`=5 and let it apply at a wrap. Then `clk_out` is low 3 / high 2 and `tick` repeats every 5 cycles.
  - Load 0, then 1. Each gives `div_active`=2, with `clk_out` toggling every cycle and `tick` every 2 cycles.
- **Mid-period reload.**
  - With N=32, load 4 at `count`=10. `pending`=1 until the wrap edge at `count`=31. `div_active` is 32 until that edge and 4 after it; the following ticks are 4 cycles apart.
  - Load 8 then 6 before one wrap: 6 takes effect.
  - Load coincident with the wrap: applies at once and `pending` never rises.
- **Enable gating.**
  - With N=8, drop `en` at `count`=3 for 7 cycles. `count` and `clk_out` freeze, `tick`=0, and the next tick is delayed by exactly 7 cycles.
  - With `en`=0 and a load, `pending` stays 1 indefinitely.
- **Reset mid-operation.** Assert `rst` at `count`=20 with `pending`=1. The next edge gives `count`=0, `clk_out`=0, `tick`=0, `pending`=0 and `div_active`=DEFAULT_DIV. The pending value is discarded.
- **Wide ratio.** With WIDTH=16, load 65535. The period is 65535 cycles, `clk_out` is low 32768 / high 32767, and `count` never exceeds 65534.
